fp_writeback_arbiter: RTL and testbench

- Owns the single write port of the floating-point register file.
- Arbitrates between two producers: the multi-cycle FPU result path and the FLW load-writeback path.
- Buffers FPU results in a small FIFO and uses a starvation counter so loads cannot lock out the FPU.
- Holds the fcsr state (frm, sticky fflags), accumulating exception flags as FPU results commit.

---
 rtl/fp_writeback_arbiter.sv | 81 ++++++++
 tb/tb_fp_writeback_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_writeback_arbiter.sv
// fp_writeback_arbiter: owns the FP register-file write port, arbitrating buffered FPU results against FLW loads, and holds fcsr.
//   CLK/nRST             : clock, asynchronous active-low reset
//   fpu_valid/fpu_ready  : FPU result handshake {fpu_rd, fpu_data, fpu_flags} into the result FIFO
//   ld_valid/ld_ready    : unbuffered load writeback handshake {ld_rd, ld_data}
//   f_wen/f_rd/f_w_data  : registered register-file write port
//   csr_wen/csr_wdata    : fcsr write {frm, fflags}
//   frm/fflags           : rounding mode and sticky exception flags
//   fifo_count           : FIFO occupancy
module fp_writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          fpu_valid,
  output logic                          fpu_ready,
  input  logic [4:0]                    fpu_rd,
  input  logic [31:0]                   fpu_data,
  input  logic [4:0]                    fpu_flags,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [4:0]                    ld_rd,
  input  logic [31:0]                   ld_data,
  output logic                          f_wen,
  output logic [4:0]                    f_rd,
  output logic [31:0]                   f_w_data,
  input  logic                          csr_wen,
  input  logic [7:0]                    csr_wdata,
  output logic [2:0]                    frm,
  output logic [4:0]                    fflags,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL  = FIFO_DEPTH[CW-1:0];
  localparam logic [SW-1:0] LIMIT = STARVE_LIMIT[SW-1:0];
  logic [4:0]    mem_rd    [FIFO_DEPTH];
  logic [31:0]   mem_data  [FIFO_DEPTH];
  logic [4:0]    mem_flags [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic          nonempty, force_fpu, enq, deq;
  assign nonempty  = fifo_count != '0;
  assign fpu_ready = fifo_count < FULL;
  assign force_fpu = (starve_cnt == LIMIT) && nonempty;
  assign ld_ready  = ld_valid && !force_fpu;
  assign enq       = fpu_valid && fpu_ready;
  // the head only issues when no load is granted, so a forced cycle always drains it
  assign deq       = !ld_ready && nonempty;
  always_ff @(posedge CLK)
    if (enq) begin
      mem_rd[wr_ptr]    <= fpu_rd;
      mem_data[wr_ptr]  <= fpu_data;
      mem_flags[wr_ptr] <= fpu_flags;
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      starve_cnt <= '0;
      f_wen      <= 1'b0;
      f_rd       <= '0;
      f_w_data   <= '0;
      frm        <= '0;
      fflags     <= '0;
    end else begin
      wr_ptr     <= enq ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= deq ? rd_ptr + 1'b1 : rd_ptr;
      fifo_count <= fifo_count + CW'(enq) - CW'(deq);
      starve_cnt <= (!nonempty || deq) ? '0
                  : (ld_ready && starve_cnt != LIMIT) ? starve_cnt + 1'b1 : starve_cnt;
      f_wen      <= ld_ready || deq;
      f_rd       <= ld_ready ? ld_rd : deq ? mem_rd[rd_ptr] : f_rd;
      f_w_data   <= ld_ready ? ld_data : deq ? mem_data[rd_ptr] : f_w_data;
      frm        <= csr_wen ? csr_wdata[7:5] : frm;
      // a CSR write overrides the flags of a head issuing in the same cycle
      fflags     <= csr_wen ? csr_wdata[4:0] : deq ? fflags | mem_flags[rd_ptr] : fflags;
    end
endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// tb_fp_writeback_arbiter: directed scoreboard bench for fp_writeback_arbiter
module tb_fp_writeback_arbiter;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  logic        CLK, nRST;
  logic        fpu_valid, fpu_ready, ld_valid, ld_ready, f_wen, csr_wen;
  logic [4:0]  fpu_rd, fpu_flags, ld_rd, f_rd, fflags;
  logic [31:0] fpu_data, ld_data, f_w_data;
  logic [7:0]  csr_wdata;
  logic [2:0]  frm;
  logic [1:0]  fifo_count;
  int          vectors = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  wr_t         got_e;
  fp_writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_flags(fpu_flags),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .f_wen(f_wen), .f_rd(f_rd), .f_w_data(f_w_data),
    .csr_wen(csr_wen), .csr_wdata(csr_wdata), .frm(frm), .fflags(fflags), .fifo_count(fifo_count)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(negedge CLK)
    if (f_wen === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", f_rd, f_w_data);
      end else begin
        got_e = exp_q.pop_front();
        if (f_rd !== got_e.rd || f_w_data !== got_e.data) begin
          miscompares++;
          $display("FAIL write: got rd=%0d data=%h, expected rd=%0d data=%h", f_rd, f_w_data, got_e.rd, got_e.data);
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic do_reset();
    nRST = 1'b0;
    fpu_valid = 1'b0;
    ld_valid = 1'b0;
    csr_wen = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask
  task automatic fpu_offer(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] fl);
    int n = 0;
    logic r;
    fpu_valid = 1'b1;
    fpu_rd = rd;
    fpu_data = d;
    fpu_flags = fl;
    do begin
      @(negedge CLK);
      r = fpu_ready;
      tick();
      n++;
    end while (!r && n < 20);
    if (!r) begin
      vectors++;
      miscompares++;
      $display("FAIL fpu_offer_timeout: got fpu_ready=0, expected 1");
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ld_idx[12] = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 8, 9, 9};
    nRST = 1'b1;
    fpu_valid = 1'b0; fpu_rd = '0; fpu_data = '0; fpu_flags = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    csr_wen = 1'b0; csr_wdata = '0;
    #1 nRST = 1'b0;
    ld_valid = 1'b1;
    tick();
    @(negedge CLK);
    chk("rst_f_wen", 32'(f_wen), 32'd0);
    chk("rst_f_rd", 32'(f_rd), 32'd0);
    chk("rst_f_w_data", f_w_data, 32'd0);
    chk("rst_frm", 32'(frm), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_fpu_ready", 32'(fpu_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    nRST = 1'b1;
    // single FPU result, no loads
    exp_q.push_back('{5'd3, 32'h3F80_0000});
    fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3F80_0000; fpu_flags = 5'b00001;
    tick();
    fpu_valid = 1'b0;
    chk("t1_no_write_n1", 32'(f_wen), 32'd0);
    tick();
    chk("t1_f_wen_n2", 32'(f_wen), 32'd1);
    chk("t1_fflags", 32'(fflags), 32'd1);
    drain();
    // starvation: loads held high while the FIFO fills
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back('{5'(8 + i), 32'h1000_0000 + i});
    exp_q.push_back('{5'd4, 32'hAAAA_0000});
    for (int i = 5; i < 9; i++) exp_q.push_back('{5'(8 + i), 32'h1000_0000 + i});
    exp_q.push_back('{5'd5, 32'hBBBB_0001});
    exp_q.push_back('{5'd17, 32'h1000_0009});
    for (int k = 0; k < 12; k++) begin
      ld_valid = 1'b1;
      ld_rd = 5'(8 + ld_idx[k]);
      ld_data = 32'h1000_0000 + ld_idx[k];
      fpu_valid = k < 2;
      fpu_rd = k == 0 ? 5'd4 : 5'd5;
      fpu_data = k == 0 ? 32'hAAAA_0000 : 32'hBBBB_0001;
      fpu_flags = '0;
      @(negedge CLK);
      if (k == 1) chk("t2_count_1", 32'(fifo_count), 32'd1);
      if (k == 2) chk("t2_fpu_ready_full", 32'(fpu_ready), 32'd0);
      if (k == 2) chk("t2_count_full", 32'(fifo_count), 32'd2);
      if (k == 4) chk("t2_ld_ready_4th", 32'(ld_ready), 32'd1);
      if (k == 5) chk("t2_forced", 32'(ld_ready), 32'd0);
      if (k == 6) chk("t2_starve_cleared", 32'(ld_ready), 32'd1);
      if (k == 6) chk("t2_count_after_force", 32'(fifo_count), 32'd1);
      if (k == 10) chk("t2_forced_again", 32'(ld_ready), 32'd0);
      if (k == 11) chk("t2_count_empty", 32'(fifo_count), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    fpu_valid = 1'b0;
    drain();
    // load and FPU together on an empty FIFO, then pointer wrap
    do_reset();
    exp_q.push_back('{5'd20, 32'hCCCC_0000});
    exp_q.push_back('{5'd21, 32'hCCCC_0001});
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'hCCCC_0000;
    fpu_valid = 1'b1; fpu_rd = 5'd21; fpu_data = 32'hCCCC_0001; fpu_flags = '0;
    @(negedge CLK);
    chk("t3_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    fpu_valid = 1'b0;
    drain();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{5'(24 + i), 32'hE000_0000 + i});
      fpu_offer(5'(24 + i), 32'hE000_0000 + i, 5'b0);
    end
    fpu_valid = 1'b0;
    drain();
    // CSR write collides with a head issue
    do_reset();
    exp_q.push_back('{5'd7, 32'h4000_0000});
    fpu_offer(5'd7, 32'h4000_0000, 5'b10000);
    fpu_valid = 1'b0;
    csr_wen = 1'b1;
    csr_wdata = 8'hA0;
    tick();
    csr_wen = 1'b0;
    chk("t4_frm", 32'(frm), 32'd5);
    chk("t4_fflags", 32'(fflags), 32'd0);
    chk("t4_f_wen", 32'(f_wen), 32'd1);
    drain();
    // reset with two FIFO entries pending
    exp_q.push_back('{5'd12, 32'h5550_0000});
    exp_q.push_back('{5'd12, 32'h5550_0002});
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h5550_0000;
    fpu_valid = 1'b1; fpu_rd = 5'd13; fpu_data = 32'h5550_0001; fpu_flags = 5'b11111;
    tick();
    ld_data = 32'h5550_0002;
    fpu_rd = 5'd14; fpu_data = 32'h5550_0003;
    tick();
    fpu_valid = 1'b0;
    ld_data = 32'h5550_0004;
    @(negedge CLK);
    chk("t5_count_pending", 32'(fifo_count), 32'd2);
    tick();
    nRST = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("t5_f_wen", 32'(f_wen), 32'd0);
    chk("t5_f_rd", 32'(f_rd), 32'd0);
    chk("t5_f_w_data", f_w_data, 32'd0);
    chk("t5_frm", 32'(frm), 32'd0);
    chk("t5_fflags", 32'(fflags), 32'd0);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_fpu_ready", 32'(fpu_ready), 32'd1);
    tick();
    tick();
    nRST = 1'b1;
    repeat (10) tick();
    chk("t5_count_idle", 32'(fifo_count), 32'd0);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    // sticky flag accumulation, then a load
    do_reset();
    exp_q.push_back('{5'd1, 32'h1111_0000});
    exp_q.push_back('{5'd2, 32'h2222_0000});
    fpu_offer(5'd1, 32'h1111_0000, 5'b00100);
    fpu_offer(5'd2, 32'h2222_0000, 5'b00010);
    fpu_valid = 1'b0;
    drain();
    chk("t6_fflags_or", 32'(fflags), 32'h6);
    exp_q.push_back('{5'd9, 32'h9999_0000});
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9999_0000;
    @(negedge CLK);
    chk("t6_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    drain();
    chk("t6_fflags_after_load", 32'(fflags), 32'h6);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
